alu_regfile_2r1w: RTL and testbench
===================================

// Module: alu_regfile_2r1w
// PURPOSE
//  Parametrised register file for the ALU datapath: one write port, two independent read ports.
//  Provides registered reads with per-port valid flags, same-cycle write-to-read bypass and a
//  sequenced bulk-clear engine. Sits between the ALU result bus and both ALU operand inputs.
// PARAMETERS
//  DATA_W  32  width of each entry in bits
//  ADDR_W  4   address width of wAddr/rAddr0/rAddr1
//  DEPTH   16  number of implemented entries, 1 <= DEPTH <= 2**ADDR_W
// PORTS
//  clk      in   1       single clock, all state updates on rising edge
//  reset    in   1       asynchronous, active-high reset
//  we       in   1       write enable
//  wAddr    in   ADDR_W  write address
//  wData    in   DATA_W  write data
//  re0      in   1       read request, port 0
//  rAddr0   in   ADDR_W  read address, port 0
//  rData0   out  DATA_W  registered read data, port 0
//  rValid0  out  1       rData0 holds the result of a request accepted last cycle
//  re1      in   1       read request, port 1
//  rAddr1   in   ADDR_W  read address, port 1
//  rData1   out  DATA_W  registered read data, port 1
//  rValid1  out  1       rData1 holds the result of a request accepted last cycle
//  clr      in   1       bulk-clear request (one-cycle pulse or level)
//  busy     out  1       clear sequence in progress
// BEHAVIOUR
//  Reset (async, while reset=1): all DEPTH entries = 0; rData0/1 = 0; rValid0/1 = 0; busy = 0;
//   FSM = IDLE; clear pointer = 0. Reset mid-clear aborts the sequence immediately.
//  FSM states: IDLE, CLEAR.
//   IDLE -> CLEAR when clr=1 at an edge; clear pointer loads 0. No write/read accepted that edge.
//   CLEAR: each edge writes 0 to entry[ptr], ptr++; when ptr==DEPTH-1 that edge -> IDLE.
//   busy = (FSM==CLEAR): high exactly DEPTH cycles per clear. clr ignored while busy.
//  Write: accepted when we=1, FSM IDLE, clr=0, wAddr<DEPTH; entry[wAddr] <= wData at the edge.
//   wAddr >= DEPTH: write dropped, no state change.
//  Read (per port p): accepted when rep=1, FSM IDLE, clr=0. Next edge: rDatap <= entry[rAddrp],
//   rValidp <= 1. Latency 1 cycle. rAddrp >= DEPTH returns 0 with rValidp=1.
//   Not accepted: rValidp <= 0, rDatap holds its previous value.
//  Bypass: accepted write and accepted read to the same in-range address on the same edge ->
//   rDatap returns the new wData (write-first). Applies to both ports independently.
//  Both read ports may address the same entry in the same cycle; both return identical data.
//  No backpressure: consumer must take rDatap in the cycle rValidp=1.
//  Any clr/write/read collision in IDLE: clr wins; write and reads dropped, rValid0/1 <= 0.
// TESTING
//  1 reset mid-op: write 0xDEADBEEF to 3, assert reset async between edges -> rData0=0, rValid0=0,
//    then re0 rAddr0=3 -> rData0=0 after 1 cycle.
//  2 dual read: write 0x11111111 @5, 0x22222222 @9; re0@5, re1@9 same cycle -> next cycle
//    rData0=0x11111111, rData1=0x22222222, both rValid=1; following idle cycle both rValid=0.
//  3 bypass: reg 7=0x0000000A; same edge we wAddr=7 wData=0x0000000B, re0/re1 rAddr=7 ->
//    rData0=rData1=0x0000000B; read again next cycle -> 0x0000000B.
//  4 clear: fill all 16 entries with index+1, pulse clr -> busy high exactly 16 cycles; writes and
//    reads during busy dropped (rValid=0); after busy falls all 16 reads return 0.
//  5 reset in CLEAR: pulse clr, assert reset after 5 busy cycles -> busy=0 at once, FSM IDLE,
//    later write/read of 0x5A5A5A5A @12 returns 0x5A5A5A5A.
//  6 DEPTH=10 build: write 0xFFFFFFFF @12 dropped; read @12 -> rData=0, rValid=1; entry 9 intact.

Source files
------------

// File: rtl/alu_regfile_2r1w.sv
// Register file with one write port and two registered read ports for the ALU datapath.
// Includes write-first bypass and a bulk-clear engine that zeroes one entry per cycle.
module alu_regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              re0,
  input  logic [ADDR_W-1:0] rAddr0,
  output logic [DATA_W-1:0] rData0,
  output logic              rValid0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] rAddr1,
  output logic [DATA_W-1:0] rData1,
  output logic              rValid1,
  input  logic              clr,
  output logic              busy,
  output logic              dbg_state_o
);

  // Handshake: a read request (reN=1) is taken whenever the block is idle and clr is low;
  // its result appears one cycle later with rValidN=1 and must be consumed in that cycle.
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                rvalid0_q, rvalid1_q;

  logic                accept;
  logic                wr_ok;
  logic                rd0_ok, rd1_ok;
  logic [DATA_W-1:0]   rdata0_d, rdata1_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  always_comb begin
    accept   = (state_q == IDLE) && !clr;
    wr_ok    = accept && we && in_range(wAddr);
    rd0_ok   = accept && re0;
    rd1_ok   = accept && re1;
    rdata0_d = '0;
    rdata1_d = '0;
    // Write-first: a same-edge write to the addressed entry is returned directly.
    if (in_range(rAddr0))
      rdata0_d = (wr_ok && (wAddr == rAddr0)) ? wData : mem_q[rAddr0];
    if (in_range(rAddr1))
      rdata1_d = (wr_ok && (wAddr == rAddr1)) ? wData : mem_q[rAddr1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
          end else begin
            if (wr_ok) mem_q[wAddr] <= wData;
            rvalid0_q <= rd0_ok;
            rvalid1_q <= rd1_ok;
            if (rd0_ok) rdata0_q <= rdata0_d;
            if (rd1_ok) rdata1_q <= rdata1_d;
          end
        end
        CLEAR: begin
          mem_q[ptr_q] <= '0;
          ptr_q        <= ptr_q + 1'b1;
          rvalid0_q    <= 1'b0;
          rvalid1_q    <= 1'b0;
          if (ptr_q == ADDR_W'(DEPTH - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rData0      = rdata0_q;
  assign rData1      = rdata1_q;
  assign rValid0     = rvalid0_q;
  assign rValid1     = rvalid1_q;
  assign busy        = (state_q == CLEAR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_regfile_2r1w.sv
// Bench for alu_regfile_2r1w: directed scenarios plus random traffic against an array model.
module tb_alu_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we, re0, re1, clr;
  logic [3:0]  wAddr, rAddr0, rAddr1;
  logic [31:0] wData, rData0, rData1;
  logic        rValid0, rValid1, busy, dbg_state;

  logic        b_we, b_re0, b_re1, b_clr;
  logic [3:0]  b_wAddr, b_rAddr0, b_rAddr1;
  logic [31:0] b_wData, b_rData0, b_rData1;
  logic        b_rValid0, b_rValid1, b_busy, b_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [16];
  logic [31:0] m_rd0, m_rd1;
  logic        m_rv0, m_rv1;
  int          m_clr_left;

  alu_regfile_2r1w #(.DATA_W(32), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData),
    .re0(re0), .rAddr0(rAddr0), .rData0(rData0), .rValid0(rValid0),
    .re1(re1), .rAddr1(rAddr1), .rData1(rData1), .rValid1(rValid1),
    .clr(clr), .busy(busy), .dbg_state_o(dbg_state)
  );

  alu_regfile_2r1w #(.DATA_W(32), .ADDR_W(4), .DEPTH(10)) dut10 (
    .clk(clk), .reset(reset), .we(b_we), .wAddr(b_wAddr), .wData(b_wData),
    .re0(b_re0), .rAddr0(b_rAddr0), .rData0(b_rData0), .rValid0(b_rValid0),
    .re1(b_re1), .rAddr1(b_rAddr1), .rData1(b_rData1), .rValid1(b_rValid1),
    .clr(b_clr), .busy(b_busy), .dbg_state_o(b_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_rd0 = '0; m_rd1 = '0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_clr_left = 0;
  endfunction

  // Reference behaviour for one rising edge, using the inputs currently applied.
  function automatic void model_edge();
    if (m_clr_left > 0) begin
      m_mem[16 - m_clr_left] = '0;
      m_clr_left--;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
    end else if (clr) begin
      m_clr_left = 16;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
    end else begin
      if (we) m_mem[wAddr] = wData;
      m_rv0 = re0; m_rv1 = re1;
      if (re0) m_rd0 = m_mem[rAddr0];
      if (re1) m_rd1 = m_mem[rAddr1];
    end
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".rData0"}, rData0, m_rd0);
    chk({ctx, ".rData1"}, rData1, m_rd1);
    chk({ctx, ".rValid0"}, 32'(rValid0), 32'(m_rv0));
    chk({ctx, ".rValid1"}, 32'(rValid1), 32'(m_rv1));
    chk({ctx, ".busy"}, 32'(busy), 32'(m_clr_left > 0));
  endtask

  // driver tasks
  task automatic step(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle();
    we = 0; re0 = 0; re1 = 0; clr = 0;
    wAddr = 0; wData = 0; rAddr0 = 0; rAddr1 = 0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    idle(); we = 1; wAddr = a; wData = d;
  endtask

  task automatic randomize_inputs(input int clr_odds);
    we = 1'($urandom_range(0, 1));
    re0 = 1'($urandom_range(0, 1));
    re1 = 1'($urandom_range(0, 1));
    clr = ($urandom_range(0, clr_odds - 1) == 0);
    wAddr = 4'($urandom_range(0, 15));
    rAddr0 = 4'($urandom_range(0, 15));
    rAddr1 = ($urandom_range(0, 3) == 0) ? wAddr : 4'($urandom_range(0, 15));
    wData = $urandom;
  endtask

  initial begin
    int busy_cycles;
    idle();
    b_we = 0; b_re0 = 0; b_re1 = 0; b_clr = 0;
    b_wAddr = 0; b_wData = 0; b_rAddr0 = 0; b_rAddr1 = 0;
    model_reset();
    reset = 1;
    #12;
    chk("reset.rValid0", 32'(rValid0), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.rData1", rData1, 32'd0);
    reset = 0;
    @(posedge clk); #1;

    // 1: async reset between edges wipes stored data
    do_write(4'd3, 32'hDEADBEEF); step("t1.wr");
    idle(); re0 = 1; rAddr0 = 4'd3; step("t1.rd");
    chk("t1.pre_reset", rData0, 32'hDEADBEEF);
    idle();
    #3; reset = 1; #1;
    model_reset();
    chk("t1.async.rData0", rData0, 32'd0);
    chk("t1.async.rValid0", 32'(rValid0), 32'd0);
    #1; reset = 0;
    step("t1.idle");
    re0 = 1; rAddr0 = 4'd3; step("t1.rd_after");
    chk("t1.rd_after_reset", rData0, 32'd0);

    // 2: independent dual read
    do_write(4'd5, 32'h11111111); step("t2.w5");
    do_write(4'd9, 32'h22222222); step("t2.w9");
    idle(); re0 = 1; rAddr0 = 4'd5; re1 = 1; rAddr1 = 4'd9; step("t2.rd");
    chk("t2.rData0", rData0, 32'h11111111);
    chk("t2.rData1", rData1, 32'h22222222);
    idle(); step("t2.idle");
    chk("t2.rValid0_low", 32'(rValid0), 32'd0);

    // 3: write-first bypass on both ports
    do_write(4'd7, 32'h0000000A); step("t3.w");
    do_write(4'd7, 32'h0000000B); re0 = 1; re1 = 1; rAddr0 = 4'd7; rAddr1 = 4'd7; step("t3.byp");
    chk("t3.byp0", rData0, 32'h0000000B);
    chk("t3.byp1", rData1, 32'h0000000B);
    idle(); re0 = 1; rAddr0 = 4'd7; step("t3.again");
    chk("t3.again0", rData0, 32'h0000000B);

    // collision: clr beats write and reads
    do_write(4'd2, 32'hCAFEF00D); re0 = 1; re1 = 1; clr = 1; step("coll");
    chk("coll.rValid0", 32'(rValid0), 32'd0);
    idle();
    while (busy) step("coll.drain");

    // 4: bulk clear of a full file
    for (int i = 0; i < 16; i++) begin
      do_write(4'(i), 32'(i + 1)); step("t4.fill");
    end
    idle(); clr = 1; step("t4.clr");
    clr = 0;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      randomize_inputs(1000);
      clr = 0;
      step("t4.busy");
    end
    chk("t4.busy_cycles", 32'(busy_cycles), 32'd16);
    for (int i = 0; i < 16; i++) begin
      idle(); re0 = 1; rAddr0 = 4'(i); re1 = 1; rAddr1 = 4'(15 - i); step("t4.rd");
      chk("t4.cleared", rData0, 32'd0);
    end

    // 5: reset aborts a clear in progress
    idle(); clr = 1; step("t5.clr");
    clr = 0;
    for (int i = 0; i < 4; i++) step("t5.busy");
    #3; reset = 1; #1;
    model_reset();
    chk("t5.busy_abort", 32'(busy), 32'd0);
    chk("t5.state_idle", 32'(dbg_state), 32'd0);
    #1; reset = 0;
    do_write(4'd12, 32'h5A5A5A5A); step("t5.w");
    idle(); re1 = 1; rAddr1 = 4'd12; step("t5.r");
    chk("t5.rd", rData1, 32'h5A5A5A5A);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      randomize_inputs(40);
      step("rand");
    end
    idle();
    while (busy) step("rand.drain");

    // 6: DEPTH=10 instance, out-of-range write dropped and read returns 0
    b_we = 1; b_wAddr = 4'd9; b_wData = 32'h99999999;
    @(posedge clk); #1;
    b_wAddr = 4'd12; b_wData = 32'hFFFFFFFF;
    @(posedge clk); #1;
    b_we = 0; b_re0 = 1; b_rAddr0 = 4'd12; b_re1 = 1; b_rAddr1 = 4'd9;
    @(posedge clk); #1;
    chk("t6.rData0", b_rData0, 32'd0);
    chk("t6.rValid0", 32'(b_rValid0), 32'd1);
    chk("t6.entry9", b_rData1, 32'h99999999);
    b_re0 = 0; b_re1 = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
